// File: rtl/indirim_pkg.sv
// rtl/indirim_pkg.sv - shared states, factor constants and factor-list builder for indirim_kasa
package indirim_pkg;

  typedef enum logic [2:0] {
    BOSTA,
    CARP,
    BOL_MILYON,
    BOL_YUZ,
    SINIRLA,
    SONUC
  } durum_t;

  localparam logic [6:0] F_PAZ1  = 7'd97;
  localparam logic [6:0] F_PAZ2  = 7'd92;
  localparam logic [6:0] F_PAZ3  = 7'd81;
  localparam logic [6:0] F_TIP0  = 7'd98;
  localparam logic [6:0] F_TIP1  = 7'd90;
  localparam logic [6:0] F_TIP2A = 7'd85;
  localparam logic [6:0] F_TIP2B = 7'd90;
  localparam logic [6:0] F_TIP4  = 7'd99;
  localparam logic [6:0] F_DAV2  = 7'd95;
  localparam logic [6:0] F_ARTIS = 7'd110;
  localparam logic [6:0] F_NOTR  = 7'd100;
  localparam logic [6:0] F_TABAN = 7'd75;

  localparam logic [19:0] BOLEN_MILYON  = 20'd1000000;
  localparam logic [19:0] BOLEN_YUZ     = 20'd100;
  localparam logic [26:0] CARPAN_ON_BIN = 27'd10000;
  localparam logic [26:0] P_TABAN       = {20'd0, F_TABAN} * {7'd0, BOLEN_MILYON};
  localparam logic [12:0] TAVAN_TAM     = 13'd5000;
  localparam int          ITERASYON     = 40;

  // Slots fill in priority order; whatever is left stays neutral (100).
  function automatic logic [3:0][6:0] faktor_listesi(
    input logic [1:0] pazarlik,
    input logic [2:0] musteri_tipi,
    input logic [1:0] davranis,
    input logic [3:0] urun_tipi
  );
    logic [3:0][6:0] s;
    logic [1:0]      n;
    s = {4{F_NOTR}};
    n = 2'd0;
    if (urun_tipi != 4'd0 && urun_tipi != 4'd2) begin
      case (pazarlik)
        2'd1:    begin s[n] = F_PAZ1; n = n + 2'd1; end
        2'd2:    begin s[n] = F_PAZ2; n = n + 2'd1; end
        2'd3:    begin s[n] = F_PAZ3; n = n + 2'd1; end
        default: ;
      endcase
      case (musteri_tipi)
        3'd0:    begin s[n] = F_TIP0; n = n + 2'd1; end
        3'd1:    begin s[n] = F_TIP1; n = n + 2'd1; end
        3'd2:    begin
          s[n] = F_TIP2A; n = n + 2'd1;
          s[n] = F_TIP2B; n = n + 2'd1;
        end
        3'd4:    begin s[n] = F_TIP4; n = n + 2'd1; end
        default: ;
      endcase
      if (davranis == 2'd2) s[n] = F_DAV2;
    end
    return s;
  endfunction

endpackage

// File: rtl/indirim_bolucu.sv
// rtl/indirim_bolucu.sv - restoring divider, 40-bit dividend / 20-bit divisor, one quotient bit per cycle
module indirim_bolucu
  import indirim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        baslat,
  input  logic [39:0] bolunen,
  input  logic [19:0] bolen,
  output logic [39:0] bolum,
  output logic [6:0]  kalan_yuz,
  output logic        mesgul,
  output logic        bitti
);

  logic [39:0] q_r, q_in, q_next;
  logic [19:0] r_r, r_in, r_next;
  logic [20:0] kaydir;
  logic        cikar;
  logic [5:0]  sayac_r;
  logic        yukle;

  assign yukle = baslat && !mesgul;
  assign bitti = mesgul && (sayac_r == 6'(ITERASYON - 1));

  // The start edge already performs the first step, so 40 edges yield 40 bits.
  always_comb begin
    q_in   = yukle ? bolunen : q_r;
    r_in   = yukle ? 20'd0 : r_r;
    kaydir = {r_in, q_in[39]};
    cikar  = kaydir >= {1'b0, bolen};
    r_next = cikar ? 20'(kaydir - {1'b0, bolen}) : kaydir[19:0];
    q_next = {q_in[38:0], cikar};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= '0;
      r_r     <= '0;
      sayac_r <= '0;
      mesgul  <= 1'b0;
    end else begin
      if (yukle || mesgul) begin
        q_r <= q_next;
        r_r <= r_next;
      end
      if (yukle) begin
        mesgul  <= 1'b1;
        sayac_r <= 6'd1;
      end else if (mesgul) begin
        sayac_r <= sayac_r + 6'd1;
        if (bitti) mesgul <= 1'b0;
      end
    end
  end

  assign bolum = q_r;
  // Only the second pass remainder (always below 100) is consumed.
  assign kalan_yuz = r_r[6:0];

endmodule

// File: rtl/indirim_kasa.sv
// rtl/indirim_kasa.sv - discounted price calculator; INDIRIM_ISTATISTIK_EN enables the result counters
module indirim_kasa
  import indirim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        giris_gecerli,
  output logic        giris_hazir,
  input  logic [12:0] urun_fiyati,
  input  logic [1:0]  pazarlik,
  input  logic [2:0]  musteri_tipi,
  input  logic [1:0]  musteri_davranisi,
  input  logic [3:0]  urun_tipi,
  output logic        cikis_gecerli,
  input  logic        cikis_hazir,
  output logic [19:0] indirimli_fiyat,
  output logic [15:0] islem_sayisi,
  output logic [15:0] tavan_sayisi
);

  durum_t          durum, durum_sonraki;
  logic [12:0]     fiyat_r;
  logic [1:0]      davranis_r;
  logic [3:0]      urun_r;
  logic [3:0][6:0] slot_r;
  logic [26:0]     carpim_r;
  logic [1:0]      adim_r;
  logic            kabul, tuketim;
  logic [6:0]      min_slot;
  logic [26:0]     p_min, p_ham, p_etkin;
  logic [39:0]     bolunen, bolum;
  logic [19:0]     bolen;
  logic            baslat, mesgul, bitti;
  logic [6:0]      kalan_yuz;
  logic            tavan_mi;
  logic [19:0]     sonuc;

  assign giris_hazir   = (durum == BOSTA);
  assign cikis_gecerli = (durum == SONUC);
  assign kabul         = giris_gecerli && giris_hazir;
  assign tuketim       = cikis_gecerli && cikis_hazir;

  always_comb begin
    min_slot = slot_r[0];
    for (int i = 1; i < 4; i++) begin
      if (slot_r[i] < min_slot) min_slot = slot_r[i];
    end
  end

  // Behaviour 0 is a surcharge on the best single factor rather than a product.
  assign p_min   = {20'd0, F_ARTIS} * {20'd0, min_slot} * CARPAN_ON_BIN;
  assign p_ham   = (davranis_r == 2'd0) ? p_min : carpim_r;
  assign p_etkin = ((davranis_r != 2'd0) && (urun_r == 4'd5 || urun_r == 4'd8) && (p_ham < P_TABAN))
                   ? P_TABAN : p_ham;

  assign tavan_mi = (bolum >= {27'd0, TAVAN_TAM});
  assign sonuc    = tavan_mi ? {TAVAN_TAM, 7'd0} : {bolum[12:0], kalan_yuz};

  always_comb begin
    durum_sonraki = durum;
    baslat        = 1'b0;
    bolunen       = {27'd0, fiyat_r} * {13'd0, p_etkin};
    bolen         = BOLEN_MILYON;
    case (durum)
      BOSTA:      if (kabul) durum_sonraki = CARP;
      CARP:       if (adim_r == 2'd3) durum_sonraki = BOL_MILYON;
      BOL_MILYON: begin
        baslat = !mesgul;
        if (bitti) durum_sonraki = BOL_YUZ;
      end
      BOL_YUZ:    begin
        bolunen = bolum;
        bolen   = BOLEN_YUZ;
        baslat  = !mesgul;
        if (bitti) durum_sonraki = SINIRLA;
      end
      SINIRLA:    durum_sonraki = SONUC;
      SONUC:      if (tuketim) durum_sonraki = BOSTA;
      default:    durum_sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) durum <= BOSTA;
    else        durum <= durum_sonraki;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fiyat_r         <= '0;
      davranis_r      <= '0;
      urun_r          <= '0;
      slot_r          <= {4{F_NOTR}};
      carpim_r        <= '0;
      adim_r          <= '0;
      indirimli_fiyat <= '0;
    end else begin
      if (kabul) begin
        fiyat_r    <= urun_fiyati;
        davranis_r <= musteri_davranisi;
        urun_r     <= urun_tipi;
        slot_r     <= faktor_listesi(pazarlik, musteri_tipi, musteri_davranisi, urun_tipi);
        carpim_r   <= 27'd1;
        adim_r     <= 2'd0;
      end
      // One shared multiplier folds in one slot per CARP cycle.
      if (durum == CARP) begin
        carpim_r <= carpim_r * {20'd0, slot_r[adim_r]};
        adim_r   <= adim_r + 2'd1;
      end
      if (durum == SINIRLA) indirimli_fiyat <= sonuc;
    end
  end

  indirim_bolucu u_bolucu (
    .clk       (clk),
    .rst_n     (rst_n),
    .baslat    (baslat),
    .bolunen   (bolunen),
    .bolen     (bolen),
    .bolum     (bolum),
    .kalan_yuz (kalan_yuz),
    .mesgul    (mesgul),
    .bitti     (bitti)
  );

`ifdef INDIRIM_ISTATISTIK_EN
  logic [15:0] islem_r, tavan_r;
  logic        tavanli_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      islem_r   <= '0;
      tavan_r   <= '0;
      tavanli_r <= 1'b0;
    end else begin
      if (durum == SINIRLA) tavanli_r <= tavan_mi;
      if (tuketim) begin
        islem_r <= islem_r + 16'd1;
        if (tavanli_r) tavan_r <= tavan_r + 16'd1;
      end
    end
  end

  assign islem_sayisi = islem_r;
  assign tavan_sayisi = tavan_r;
`else
  assign islem_sayisi = 16'd0;
  assign tavan_sayisi = 16'd0;
`endif

endmodule

// File: doc/indirim_kasa.md
INDIRIM_KASA -- requirements
Module: indirim_kasa

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port giris_gecerli, input, 1 bit: request valid.
REQ-004 SHALL have port giris_hazir, output, 1 bit: block can accept a request.
REQ-005 SHALL have request fields, all inputs: urun_fiyati[12:0], pazarlik[1:0], musteri_tipi[2:0], musteri_davranisi[1:0], urun_tipi[3:0].
REQ-006 SHALL have port cikis_gecerli, output, 1 bit: result valid.
REQ-007 SHALL have port cikis_hazir, input, 1 bit: consumer accepts the result.
REQ-008 SHALL have port indirimli_fiyat, output, 20 bits: {tam[12:0], kurus[6:0]}, kurus 0..99.
REQ-009 SHALL have ports islem_sayisi and tavan_sayisi, outputs, 16 bits each: statistics counters (REQ-026).

Function
REQ-010 SHALL accept a request on an edge where giris_gecerli && giris_hazir, registering all fields; fields are ignored at other times.
REQ-011 SHALL drive giris_hazir high only in state BOSTA.
REQ-012 SHALL use FSM states BOSTA -> CARP (4 cycles) -> BOL_MILYON (40) -> BOL_YUZ (40) -> SINIRLA (1) -> SONUC -> BOSTA.
REQ-013 SHALL assert cikis_gecerli exactly 85 rising edges after the accepting edge.
REQ-014 SHALL build a 4-slot factor list, unused slots = 100. Urun_tipi 0 or 2 contributes no factors. Otherwise, in order:
- pazarlik 1/2/3 -> 97/92/81
- musteri_tipi 0->98, 1->90, 2->85 then 90, 4->99
- musteri_davranisi 2->95
REQ-015 SHALL form P for musteri_davranisi 0 as 110*m*10000, where m = minimum slot value (100 if no factors).
REQ-016 SHALL form P for musteri_davranisi 1..3 as the product of the four slots, computed in CARP using one shared multiplier, one slot per cycle.
REQ-017 SHALL replace P with 75000000 when musteri_davranisi != 0, urun_tipi is 5 or 8, and P < 75000000.
REQ-018 SHALL compute the dividend D = urun_fiyati*P in 40-bit arithmetic with no overflow.
REQ-019 SHALL compute q = floor(D/1000000) in BOL_MILYON, then tam = floor(q/100) and kurus = q mod 100 in BOL_YUZ.
REQ-020 SHALL, in SINIRLA, force the result to tam=5000, kurus=0 when tam >= 5000.
REQ-021 SHALL hold indirimli_fiyat and cikis_gecerli stable in SONUC until cikis_hazir is high; that edge returns the FSM to BOSTA.
REQ-022 SHALL not accept a new request on the same edge a result is consumed; the earliest next accept is the following edge.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-operation, abort immediately:
- FSM = BOSTA
- cikis_gecerli=0, indirimli_fiyat=0
- both counters = 0
- divider idle
REQ-024 SHALL drive giris_hazir=1 on the first edge after rst_n deasserts.

Configuration
REQ-025 SHALL use the macro INDIRIM_ISTATISTIK_EN to enable statistics.
REQ-026 SHALL, with the macro defined, increment islem_sayisi on each consumed result and increment tavan_sayisi on each consumed result that was capped; both counters wrap at 16 bits.
REQ-027 SHALL, without the macro, keep both counter ports present but tied to 0, with no counter registers synthesized.

Structure
REQ-028 SHALL place in shared package indirim_pkg: the FSM state enum, factor constants (97, 92, 81, 98, 90, 85, 99, 95, 110, 100, 75), divisor constants 1000000 and 100, cap 5000, and iteration count 40.
REQ-029 SHALL instantiate one sub-module, indirim_bolucu: a sequential restoring divider with 40-bit dividend, 20-bit divisor, start/done, one bit per cycle, 40 cycles.
REQ-030 SHALL reuse indirim_bolucu for both division passes.

Verification
REQ-031 SHALL cover: fiyat=1000, pazarlik=0, tip=3, davranis=1, urun=1 -> indirimli_fiyat={1000,0}, cikis_gecerli at edge 85.
REQ-032 SHALL cover: fiyat=1000, pazarlik=3, tip=2, davranis=2 -> with urun=1, {588,66}; with urun=5, {750,0}.
REQ-033 SHALL cover: fiyat=200, pazarlik=1, tip=1, davranis=0, urun=1 -> {198,0}.
REQ-034 SHALL cover: fiyat=8000, urun=0, davranis=0 -> {5000,0} (raw 8800 capped).
REQ-035 SHALL cover: cikis_hazir=0 for 10 cycles in SONUC -> output stable, giris_hazir=0. Then a separate run with rst_n pulsed low 20 cycles after accept -> all outputs 0 and giris_hazir=1 after release.
REQ-036 SHALL cover: with INDIRIM_ISTATISTIK_EN defined, two consumed results, one capped -> islem_sayisi=2, tavan_sayisi=1; without the macro -> both 0.
